// File: rtl/noc_router_xy.sv
// noc_router_xy: one 5-port (L, N, E, S, W) mesh router tile for single-flit
// packets. Each input has a small FIFO; each output has one register and a
// round-robin arbiter. Heads are routed X-first against the tile coordinates;
// heads that would go to a missing neighbour or U-turn are discarded and counted.
module noc_router_xy #(
    parameter logic [3:0] XCOORD = 4'b0100,
    parameter logic [3:0] YCOORD = 4'b0100,
    parameter bit         NORTH  = 1'b1,
    parameter bit         SOUTH  = 1'b1,
    parameter bit         EAST   = 1'b1,
    parameter bit         WEST   = 1'b1,
    parameter int         DATA_W = 32,
    parameter int         DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              n_in_valid,
    input  logic [DATA_W-1:0] n_in_data,
    output logic              n_in_ready,
    output logic              n_out_valid,
    output logic [DATA_W-1:0] n_out_data,
    input  logic              n_out_ready,

    input  logic              s_in_valid,
    input  logic [DATA_W-1:0] s_in_data,
    output logic              s_in_ready,
    output logic              s_out_valid,
    output logic [DATA_W-1:0] s_out_data,
    input  logic              s_out_ready,

    input  logic              e_in_valid,
    input  logic [DATA_W-1:0] e_in_data,
    output logic              e_in_ready,
    output logic              e_out_valid,
    output logic [DATA_W-1:0] e_out_data,
    input  logic              e_out_ready,

    input  logic              w_in_valid,
    input  logic [DATA_W-1:0] w_in_data,
    output logic              w_in_ready,
    output logic              w_out_valid,
    output logic [DATA_W-1:0] w_out_data,
    input  logic              w_out_ready,

    input  logic              l_in_valid,
    input  logic [DATA_W-1:0] l_in_data,
    output logic              l_in_ready,
    output logic              l_out_valid,
    output logic [DATA_W-1:0] l_out_data,
    input  logic              l_out_ready,

    input  logic              ctrl_en,
    output logic              ctrl_drop,
    output logic [15:0]       ctrl_drop_cnt
);

    // Port indices double as the round-robin priority order L, N, E, S, W.
    localparam int         NP  = 5;
    localparam logic [2:0] P_L = 3'd0;
    localparam logic [2:0] P_N = 3'd1;
    localparam logic [2:0] P_E = 3'd2;
    localparam logic [2:0] P_S = 3'd3;
    localparam logic [2:0] P_W = 3'd4;
    localparam int         AW  = $clog2(DEPTH);
    localparam int         CW  = AW + 1;

    // Local is always present; mesh-edge tiles drop the missing neighbours.
    localparam logic [NP-1:0] PRESENT = {WEST, SOUTH, EAST, NORTH, 1'b1};

    // Port bundles packed into arrays indexed by port number.
    logic [NP-1:0]     w_in_valid_v;
    logic [NP-1:0]     w_out_ready_v;
    logic [NP-1:0]     w_in_ready_v;
    logic [DATA_W-1:0] w_in_data_a [NP];

    // Input FIFOs.
    logic [DATA_W-1:0] r_mem    [NP][DEPTH];
    logic [AW-1:0]     r_rd_ptr [NP];
    logic [AW-1:0]     r_wr_ptr [NP];
    logic [CW-1:0]     r_cnt    [NP];
    logic [NP-1:0]     w_full;
    logic [NP-1:0]     w_empty;
    logic [NP-1:0]     w_push;
    logic [NP-1:0]     w_pop;
    logic [DATA_W-1:0] w_head   [NP];

    // Routing, arbitration and output stage.
    logic [2:0]        w_route     [NP];
    logic [NP-1:0]     w_drop;
    logic [NP-1:0]     w_req       [NP];
    logic [NP-1:0]     w_out_free;
    logic [NP-1:0]     w_grant_any;
    logic [2:0]        w_grant_idx [NP];
    logic [DATA_W-1:0] w_out_next  [NP];
    logic [2:0]        r_rr_ptr    [NP];
    logic [NP-1:0]     r_out_valid;
    logic [DATA_W-1:0] r_out_data  [NP];

    // Discard accounting.
    logic [2:0]        w_drop_num;
    logic [16:0]       w_drop_sum;
    logic [15:0]       r_drop_cnt;

    // Absent ports have their inputs masked so they never push or drain.
    assign w_in_valid_v  = {w_in_valid, s_in_valid, e_in_valid, n_in_valid, l_in_valid} & PRESENT;
    assign w_out_ready_v = {w_out_ready, s_out_ready, e_out_ready, n_out_ready, l_out_ready} & PRESENT;

    assign w_in_data_a[P_L] = l_in_data;
    assign w_in_data_a[P_N] = n_in_data;
    assign w_in_data_a[P_E] = e_in_data;
    assign w_in_data_a[P_S] = s_in_data;
    assign w_in_data_a[P_W] = w_in_data;

    // FIFO status from registered counts only, so in_ready never sees pops.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch so no latch is inferred.
        w_full  = '0;
        w_empty = '0;
        for (int i = 0; i < NP; i++) begin
            w_full[i]  = (r_cnt[i] == CW'(DEPTH));
            w_empty[i] = (r_cnt[i] == '0);
            w_head[i]  = r_mem[i][r_rd_ptr[i]];
        end
    end

    assign w_in_ready_v = PRESENT & ~w_full;
    assign w_push       = w_in_valid_v & ~w_full;

    // XY route of each FIFO head, and discard of heads that cannot be forwarded.
    always_comb begin
        logic [3:0] dx;
        logic [3:0] dy;
        w_drop = '0;
        for (int i = 0; i < NP; i++) begin
            dx = w_head[i][DATA_W-1 -: 4];
            dy = w_head[i][DATA_W-5 -: 4];
            if (dx > XCOORD)      w_route[i] = P_E;
            else if (dx < XCOORD) w_route[i] = P_W;
            else if (dy > YCOORD) w_route[i] = P_N;
            else if (dy < YCOORD) w_route[i] = P_S;
            else                  w_route[i] = P_L;
            // Local-to-Local is a delivery, not a U-turn.
            w_drop[i] = ctrl_en & ~w_empty[i] & (w_route[i] != P_L)
                      & (~PRESENT[w_route[i]] | (w_route[i] == 3'(i)));
        end
    end

    // Requests per output: head routed here, output able to take a flit this cycle.
    always_comb begin
        w_out_free = ~r_out_valid | w_out_ready_v;
        for (int o = 0; o < NP; o++) begin
            w_req[o] = '0;
            for (int i = 0; i < NP; i++) begin
                w_req[o][i] = ctrl_en & ~w_empty[i] & ~w_drop[i] & (w_route[i] == 3'(o))
                            & PRESENT[o] & w_out_free[o];
            end
        end
    end

    // Round-robin pick: scan from the pointer, first requester wins.
    always_comb begin
        int idx;
        w_grant_any = '0;
        for (int o = 0; o < NP; o++) begin
            w_grant_idx[o] = P_L;
            for (int k = 0; k < NP; k++) begin
                idx = int'(r_rr_ptr[o]) + k;
                if (idx >= NP) idx = idx - NP;
                if (!w_grant_any[o] && w_req[o][idx]) begin
                    w_grant_any[o] = 1'b1;
                    w_grant_idx[o] = 3'(idx);
                end
            end
            w_out_next[o] = w_head[w_grant_idx[o]];
        end
    end

    // A head leaves its FIFO when granted by its output or when discarded.
    always_comb begin
        w_pop = w_drop;
        for (int o = 0; o < NP; o++) begin
            if (w_grant_any[o]) w_pop[w_grant_idx[o]] = 1'b1;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            for (int i = 0; i < NP; i++) begin
                r_rd_ptr[i] <= '0;
                r_wr_ptr[i] <= '0;
                r_cnt[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < NP; i++) begin
                if (w_push[i]) r_wr_ptr[i] <= r_wr_ptr[i] + AW'(1);
                if (w_pop[i])  r_rd_ptr[i] <= r_rd_ptr[i] + AW'(1);
                case ({w_push[i], w_pop[i]})
                    2'b10:   r_cnt[i] <= r_cnt[i] + CW'(1);
                    2'b01:   r_cnt[i] <= r_cnt[i] - CW'(1);
                    default: r_cnt[i] <= r_cnt[i];
                endcase
            end
        end
    end

    // FIFO storage writes.
    always_ff @(posedge clk) begin
        // NOTE: storage has no reset; emptiness is tracked by the reset counters, so stale words are never read out.
        for (int i = 0; i < NP; i++) begin
            if (w_push[i]) r_mem[i][r_wr_ptr[i]] <= w_in_data_a[i];
        end
    end

    // Output registers: load on grant, otherwise clear once the flit is taken.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= '0;
            for (int o = 0; o < NP; o++) r_out_data[o] <= '0;
        end else begin
            for (int o = 0; o < NP; o++) begin
                if (w_grant_any[o]) begin
                    r_out_valid[o] <= 1'b1;
                    r_out_data[o]  <= w_out_next[o];
                end else if (w_out_ready_v[o]) begin
                    r_out_valid[o] <= 1'b0;
                end
            end
        end
    end

    // Round-robin pointers move to just after the granted input.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int o = 0; o < NP; o++) r_rr_ptr[o] <= P_L;
        end else begin
            for (int o = 0; o < NP; o++) begin
                if (w_grant_any[o]) begin
                    r_rr_ptr[o] <= (w_grant_idx[o] == P_W) ? P_L : w_grant_idx[o] + 3'd1;
                end
            end
        end
    end

    // Number of flits discarded this cycle.
    always_comb begin
        w_drop_num = '0;
        for (int i = 0; i < NP; i++) w_drop_num = w_drop_num + {2'b00, w_drop[i]};
        w_drop_sum = {1'b0, r_drop_cnt} + 17'(w_drop_num);
    end

    // Saturating discard counter.
    always_ff @(posedge clk) begin
        if (!rst_n) r_drop_cnt <= '0;
        else        r_drop_cnt <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
    end

    assign ctrl_drop     = |w_drop;
    assign ctrl_drop_cnt = r_drop_cnt;

    assign l_in_ready  = w_in_ready_v[P_L];
    assign n_in_ready  = w_in_ready_v[P_N];
    assign e_in_ready  = w_in_ready_v[P_E];
    assign s_in_ready  = w_in_ready_v[P_S];
    assign w_in_ready  = w_in_ready_v[P_W];

    assign l_out_valid = r_out_valid[P_L];
    assign n_out_valid = r_out_valid[P_N];
    assign e_out_valid = r_out_valid[P_E];
    assign s_out_valid = r_out_valid[P_S];
    assign w_out_valid = r_out_valid[P_W];

    assign l_out_data  = r_out_data[P_L];
    assign n_out_data  = r_out_data[P_N];
    assign e_out_data  = r_out_data[P_E];
    assign s_out_data  = r_out_data[P_S];
    assign w_out_data  = r_out_data[P_W];

endmodule

// File: tb/tb_noc_router_xy.sv
// tb_noc_router_xy: directed bench for noc_router_xy at tile (4,4). A second
// instance with the East neighbour absent shares the stimulus for the
// discard case. Inputs change and outputs are sampled on the falling edge.
module tb_noc_router_xy;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ctrl_en = 1'b1;

    logic        n_in_valid = 1'b0, s_in_valid = 1'b0, e_in_valid = 1'b0, w_in_valid = 1'b0, l_in_valid = 1'b0;
    logic [31:0] n_in_data = '0, s_in_data = '0, e_in_data = '0, w_in_data = '0, l_in_data = '0;
    logic        n_out_ready = 1'b1, s_out_ready = 1'b1, e_out_ready = 1'b1, w_out_ready = 1'b1, l_out_ready = 1'b1;

    logic        n_in_ready, s_in_ready, e_in_ready, w_in_ready, l_in_ready;
    logic        n_out_valid, s_out_valid, e_out_valid, w_out_valid, l_out_valid;
    logic [31:0] n_out_data, s_out_data, e_out_data, w_out_data, l_out_data;
    logic        ctrl_drop;
    logic [15:0] ctrl_drop_cnt;

    logic        x_n_in_ready, x_s_in_ready, x_e_in_ready, x_w_in_ready, x_l_in_ready;
    logic        x_n_out_valid, x_s_out_valid, x_e_out_valid, x_w_out_valid, x_l_out_valid;
    logic [31:0] x_n_out_data, x_s_out_data, x_e_out_data, x_w_out_data, x_l_out_data;
    logic        x_ctrl_drop;
    logic [15:0] x_ctrl_drop_cnt;

    int n_errors = 0;
    int n_checks = 0;

    // Port numbering used by the bench vectors: L=0, N=1, E=2, S=3, W=4.
    wire [4:0] ov = {w_out_valid, s_out_valid, e_out_valid, n_out_valid, l_out_valid};
    wire [4:0] ir = {w_in_ready, s_in_ready, e_in_ready, n_in_ready, l_in_ready};

    always #5 clk = ~clk;

    noc_router_xy #(.XCOORD(4'd4), .YCOORD(4'd4), .DATA_W(32), .DEPTH(4)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .n_in_valid(n_in_valid), .n_in_data(n_in_data), .n_in_ready(n_in_ready),
        .n_out_valid(n_out_valid), .n_out_data(n_out_data), .n_out_ready(n_out_ready),
        .s_in_valid(s_in_valid), .s_in_data(s_in_data), .s_in_ready(s_in_ready),
        .s_out_valid(s_out_valid), .s_out_data(s_out_data), .s_out_ready(s_out_ready),
        .e_in_valid(e_in_valid), .e_in_data(e_in_data), .e_in_ready(e_in_ready),
        .e_out_valid(e_out_valid), .e_out_data(e_out_data), .e_out_ready(e_out_ready),
        .w_in_valid(w_in_valid), .w_in_data(w_in_data), .w_in_ready(w_in_ready),
        .w_out_valid(w_out_valid), .w_out_data(w_out_data), .w_out_ready(w_out_ready),
        .l_in_valid(l_in_valid), .l_in_data(l_in_data), .l_in_ready(l_in_ready),
        .l_out_valid(l_out_valid), .l_out_data(l_out_data), .l_out_ready(l_out_ready),
        .ctrl_en(ctrl_en), .ctrl_drop(ctrl_drop), .ctrl_drop_cnt(ctrl_drop_cnt)
    );

    noc_router_xy #(.XCOORD(4'd4), .YCOORD(4'd4), .EAST(1'b0), .DATA_W(32), .DEPTH(4)) u_dut_edge (
        .clk(clk), .rst_n(rst_n),
        .n_in_valid(n_in_valid), .n_in_data(n_in_data), .n_in_ready(x_n_in_ready),
        .n_out_valid(x_n_out_valid), .n_out_data(x_n_out_data), .n_out_ready(n_out_ready),
        .s_in_valid(s_in_valid), .s_in_data(s_in_data), .s_in_ready(x_s_in_ready),
        .s_out_valid(x_s_out_valid), .s_out_data(x_s_out_data), .s_out_ready(s_out_ready),
        .e_in_valid(e_in_valid), .e_in_data(e_in_data), .e_in_ready(x_e_in_ready),
        .e_out_valid(x_e_out_valid), .e_out_data(x_e_out_data), .e_out_ready(e_out_ready),
        .w_in_valid(w_in_valid), .w_in_data(w_in_data), .w_in_ready(x_w_in_ready),
        .w_out_valid(x_w_out_valid), .w_out_data(x_w_out_data), .w_out_ready(w_out_ready),
        .l_in_valid(l_in_valid), .l_in_data(l_in_data), .l_in_ready(x_l_in_ready),
        .l_out_valid(x_l_out_valid), .l_out_data(x_l_out_data), .l_out_ready(l_out_ready),
        .ctrl_en(ctrl_en), .ctrl_drop(x_ctrl_drop), .ctrl_drop_cnt(x_ctrl_drop_cnt)
    );

    task automatic check(input string name, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", name, observed, expected);
        end
    endtask

    // Advance n rising edges and return on the following falling edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    function automatic logic [31:0] out_data(input int p);
        case (p)
            0:       return l_out_data;
            1:       return n_out_data;
            2:       return e_out_data;
            3:       return s_out_data;
            default: return w_out_data;
        endcase
    endfunction

    logic [31:0] route_flit [5];
    int          route_port [5];
    logic [31:0] base;
    int          sent, rcv, cycles;
    logic        acc;

    initial begin
        route_flit[0] = 32'h7400_0001; route_port[0] = 2;  // 7,4 -> East
        route_flit[1] = 32'h4400_0002; route_port[1] = 0;  // 4,4 -> Local
        route_flit[2] = 32'h4900_0003; route_port[2] = 1;  // 4,9 -> North
        route_flit[3] = 32'h4100_0004; route_port[3] = 3;  // 4,1 -> South
        route_flit[4] = 32'h2900_0005; route_port[4] = 4;  // 2,9 -> West (X first)

        // Reset state.
        @(negedge clk);
        tick(2);
        check("reset_out_valid", 32'(ov), 32'h0);
        check("reset_in_ready", 32'(ir), 32'h1F);
        check("reset_drop_cnt", 32'(ctrl_drop_cnt), 32'h0);
        check("reset_e_out_data", e_out_data, 32'h0);
        rst_n = 1'b1;
        tick(1);

        // Single flits from Local to each direction.
        for (int t = 0; t < 5; t++) begin
            check("route_in_ready", 32'(l_in_ready), 32'h1);
            l_in_valid = 1'b1;
            l_in_data  = route_flit[t];
            tick(1);
            l_in_valid = 1'b0;
            l_in_data  = '0;
            check("route_not_early", 32'(ov), 32'h0);
            tick(1);
            check("route_out_valid", 32'(ov), 32'h1 << route_port[t]);
            check("route_out_data", out_data(route_port[t]), route_flit[t]);
            tick(1);
            check("route_drained", 32'(ov), 32'h0);
        end

        // Three inputs contend for East: expect N, S, W on consecutive cycles.
        n_in_valid = 1'b1; n_in_data = 32'h7100_00A1;
        s_in_valid = 1'b1; s_in_data = 32'h7200_00B2;
        w_in_valid = 1'b1; w_in_data = 32'h7300_00C3;
        tick(1);
        n_in_valid = 1'b0; s_in_valid = 1'b0; w_in_valid = 1'b0;
        check("rr_not_early", 32'(e_out_valid), 32'h0);
        tick(1);
        check("rr_first_valid", 32'(e_out_valid), 32'h1);
        check("rr_first_is_n", e_out_data, 32'h7100_00A1);
        tick(1);
        check("rr_second_valid", 32'(e_out_valid), 32'h1);
        check("rr_second_is_s", e_out_data, 32'h7200_00B2);
        tick(1);
        check("rr_third_valid", 32'(e_out_valid), 32'h1);
        check("rr_third_is_w", e_out_data, 32'h7300_00C3);
        tick(1);
        check("rr_done", 32'(e_out_valid), 32'h0);

        // Backpressure: East stalled, Local streams 10 flits.
        base = 32'h7400_0100;
        e_out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("bp_ready_filling", 32'(l_in_ready), 32'h1);
            l_in_valid = 1'b1;
            l_in_data  = base + 32'(i);
            tick(1);
        end
        l_in_data = base + 32'd5;
        check("bp_ready_full", 32'(l_in_ready), 32'h0);
        check("bp_out_held_valid", 32'(e_out_valid), 32'h1);
        check("bp_out_held_data", e_out_data, base);
        tick(2);
        check("bp_ready_still_full", 32'(l_in_ready), 32'h0);
        e_out_ready = 1'b1;
        sent = 5; rcv = 0; cycles = 0;
        while (rcv < 10 && cycles < 60) begin
            if (e_out_valid) begin
                check("bp_order", e_out_data, base + 32'(rcv));
                rcv++;
            end
            acc = l_in_valid && l_in_ready;
            tick(1);
            cycles++;
            if (acc) begin
                sent++;
                if (sent < 10) l_in_data = base + 32'(sent);
                else begin
                    l_in_valid = 1'b0;
                    l_in_data  = '0;
                end
            end
        end
        check("bp_all_sent", 32'(sent), 32'd10);
        check("bp_all_received", 32'(rcv), 32'd10);
        tick(1);
        check("bp_idle", 32'(e_out_valid), 32'h0);

        // Frozen arbitration holds a buffered flit until ctrl_en returns.
        ctrl_en = 1'b0;
        l_in_valid = 1'b1; l_in_data = 32'h4900_0077;
        tick(1);
        l_in_valid = 1'b0; l_in_data = '0;
        tick(3);
        check("frozen_no_output", 32'(n_out_valid), 32'h0);
        ctrl_en = 1'b1;
        tick(1);
        check("unfrozen_valid", 32'(n_out_valid), 32'h1);
        check("unfrozen_data", n_out_data, 32'h4900_0077);
        tick(1);

        // Missing East neighbour: the flit is discarded and counted.
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        check("edge_reset_cnt", 32'(x_ctrl_drop_cnt), 32'h0);
        check("edge_e_in_ready", 32'(x_e_in_ready), 32'h0);
        l_in_valid = 1'b1; l_in_data = 32'h7400_0099;
        tick(1);
        l_in_valid = 1'b0; l_in_data = '0;
        check("edge_drop_pulse", 32'(x_ctrl_drop), 32'h1);
        check("edge_cnt_before", 32'(x_ctrl_drop_cnt), 32'h0);
        tick(1);
        check("edge_drop_done", 32'(x_ctrl_drop), 32'h0);
        check("edge_cnt_one", 32'(x_ctrl_drop_cnt), 32'h1);
        check("edge_e_out_valid", 32'(x_e_out_valid), 32'h0);
        check("edge_e_out_data", x_e_out_data, 32'h0);
        check("full_tile_forwards", e_out_data, 32'h7400_0099);
        tick(1);

        // U-turn: a North input flit headed north is discarded by the full tile.
        n_in_valid = 1'b1; n_in_data = 32'h4900_0055;
        tick(1);
        n_in_valid = 1'b0; n_in_data = '0;
        check("uturn_drop_pulse", 32'(ctrl_drop), 32'h1);
        tick(1);
        check("uturn_drop_cnt", 32'(ctrl_drop_cnt), 32'h1);
        check("uturn_no_output", 32'(n_out_valid), 32'h0);
        check("uturn_pulse_ends", 32'(ctrl_drop), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
